// File: rtl/i2c_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_ctrl_pkg
// Brief  : Shared state/phase encodings, constants and bus-drive decode for
//          the single-master I2C controller.
// Rev    : 1.0  initial release
// ============================================================================
package i2c_ctrl_pkg;

    typedef logic [2:0] state_t;
    localparam state_t c_IDLE  = 3'd0;
    localparam state_t c_START = 3'd1;
    localparam state_t c_ADDR  = 3'd2;
    localparam state_t c_DATA  = 3'd3;
    localparam state_t c_STOP  = 3'd4;
    localparam state_t c_DONE  = 3'd5;

    typedef logic [1:0] phase_t;
    localparam phase_t c_Q0 = 2'd0;
    localparam phase_t c_Q1 = 2'd1;
    localparam phase_t c_Q2 = 2'd2;
    localparam phase_t c_Q3 = 2'd3;

    localparam int         BITS_PER_BYTE = 9;
    localparam logic [6:0] DEFAULT_ADR   = 7'h70;

    // Returns {scl_low, sda_low} for a given state/phase; sda_bit is the
    // data-bit pull-down used during ADDR/DATA bits.
    function automatic logic [1:0] bus_drive(input state_t st, input phase_t ph,
                                             input logic sda_bit);
        logic scl_l;
        logic sda_l;
        scl_l = 1'b0;
        sda_l = 1'b0;
        case (st)
            c_START: begin
                scl_l = (ph == c_Q3);
                sda_l = (ph == c_Q2) || (ph == c_Q3);
            end
            c_ADDR, c_DATA: begin
                scl_l = (ph == c_Q0) || (ph == c_Q3);
                sda_l = sda_bit;
            end
            c_STOP: begin
                scl_l = (ph == c_Q0);
                sda_l = (ph == c_Q0) || (ph == c_Q1);
            end
            default: begin
                scl_l = 1'b0;
                sda_l = 1'b0;
            end
        endcase
        return {scl_l, sda_l};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_master_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : i2c_tick_gen
// Brief  : Quarter-bit tick divider; tick when the counter hits CLK_DIV-1.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : i2c_master_ctrl
// Brief  : Single-master I2C controller for one-byte write/read transactions
//          with open-drain SCL/SDA enables and an ACK/NACK response.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_master_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_adr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       scl_low,
    output logic       sda_low,
    input  logic       sda_in
);

    localparam logic [3:0] c_LAST_BIT = 4'(BITS_PER_BYTE - 1);

    state_t     r_state;
    phase_t     r_phase;
    logic [3:0] r_bit;
    logic       r_rw;
    logic [6:0] r_adr;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic       r_nack;
    logic [7:0] r_rdata;
    logic       r_scl_low;
    logic       r_sda_low;

    state_t     w_state_nxt;
    phase_t     w_phase_nxt;
    logic [3:0] w_bit_nxt;
    logic       w_tick;
    logic       w_accept;
    logic       w_sample;
    logic [7:0] w_tx_byte;
    logic [2:0] w_bit_sel;
    logic       w_sda_bit;
    logic [1:0] w_drv;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state == c_IDLE),
        .o_tick  (w_tick)
    );

    assign w_accept  = cmd_valid && (r_state == c_IDLE);
    assign w_sample  = w_tick && (r_phase == c_Q1);
    assign cmd_ready = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = (r_state == c_DONE);
    assign rsp_nack  = (r_state == c_DONE) && r_nack;
    assign rsp_rdata = r_rdata;
    assign scl_low   = r_scl_low;
    assign sda_low   = r_sda_low;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_START;
                    w_phase_nxt = c_Q0;
                    w_bit_nxt   = 4'd0;
                end
            end
            c_DONE: w_state_nxt = c_IDLE;
            default: begin
                if (w_tick) begin
                    w_phase_nxt = phase_t'(r_phase + 2'd1);
                    if (r_phase == c_Q3) begin
                        case (r_state)
                            c_START: begin
                                w_state_nxt = c_ADDR;
                                w_bit_nxt   = 4'd0;
                            end
                            c_ADDR: begin
                                if (r_bit == c_LAST_BIT) begin
                                    w_state_nxt = r_nack ? c_STOP : c_DATA;
                                    w_bit_nxt   = 4'd0;
                                end else begin
                                    w_bit_nxt = r_bit + 4'd1;
                                end
                            end
                            c_DATA: begin
                                if (r_bit == c_LAST_BIT) begin
                                    w_state_nxt = c_STOP;
                                end else begin
                                    w_bit_nxt = r_bit + 4'd1;
                                end
                            end
                            c_STOP:  w_state_nxt = c_DONE;
                            default: w_state_nxt = c_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Drive for the upcoming bit; the ninth bit and all read data bits release SDA.
    always_comb begin
        w_tx_byte = (w_state_nxt == c_ADDR) ? {r_adr, r_rw} : r_wdata;
        w_bit_sel = 3'd7 - w_bit_nxt[2:0];
        w_sda_bit = ((w_state_nxt == c_ADDR) || ((w_state_nxt == c_DATA) && !r_rw))
                    && !w_bit_nxt[3] && !w_tx_byte[w_bit_sel];
        w_drv     = bus_drive(w_state_nxt, w_phase_nxt, w_sda_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_phase   <= c_Q0;
            r_bit     <= 4'd0;
            r_rw      <= 1'b0;
            r_adr     <= 7'd0;
            r_wdata   <= 8'd0;
            r_shift   <= 8'd0;
            r_nack    <= 1'b0;
            r_rdata   <= 8'd0;
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit     <= w_bit_nxt;
            r_scl_low <= w_drv[1];
            r_sda_low <= w_drv[0];
            if (w_accept) begin
                r_rw    <= cmd_rw;
                r_adr   <= cmd_adr;
                r_wdata <= cmd_wdata;
                r_nack  <= 1'b0;
            end
            if (w_sample) begin
                if ((r_state == c_ADDR) && (r_bit == c_LAST_BIT)) begin
                    r_nack <= sda_in;
                end else if ((r_state == c_DATA) && !r_rw && (r_bit == c_LAST_BIT)) begin
                    r_nack <= sda_in;
                end else if ((r_state == c_DATA) && r_rw && !r_bit[3]) begin
                    r_shift <= {r_shift[6:0], sda_in};
                end
            end
            // Publish read data together with the response pulse.
            if ((r_state == c_STOP) && w_tick && (r_phase == c_Q3) && r_rw && !r_nack) begin
                r_rdata <= r_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_master_ctrl
// Brief  : Bench for i2c_master_ctrl with an IO-extender slave at 7'h70 and
//          a waveform-level reference of the expected bus and status outputs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2c_master_ctrl;

    localparam int         CD  = 4;
    localparam logic [6:0] SLV = 7'h70;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_adr = 7'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_low, sda_low;
    logic [7:0] rsp_rdata;
    logic       w_scl, w_sda;

    // slave (IO extender) state
    logic       s_drv = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         s_st = 0;
    int         s_bit = 0;
    logic [7:0] s_sh = 8'd0;
    logic       s_rw = 1'b0;
    logic [7:0] s_io = 8'hFF;
    logic       s_mack = 1'b0;
    int         s_stops = 0;

    assign w_scl = ~scl_low;
    assign w_sda = ~(sda_low | s_drv);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_adr   (cmd_adr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .scl_low   (scl_low),
        .sda_low   (sda_low),
        .sda_in    (w_sda)
    );

    // Slave: st 0 idle, 1 address, 2 write data, 3 read data, 4 wait for STOP
    always @(posedge clk) begin
        p_scl <= w_scl;
        p_sda <= w_sda;
        if (p_scl && w_scl && p_sda && !w_sda) begin
            s_st  <= 1;
            s_bit <= 0;
            s_drv <= 1'b0;
        end else if (p_scl && w_scl && !p_sda && w_sda) begin
            s_st    <= 0;
            s_drv   <= 1'b0;
            s_stops <= s_stops + 1;
        end else if (!p_scl && w_scl) begin
            if (s_st != 0 && s_st != 4) begin
                if (s_bit < 8) s_sh <= {s_sh[6:0], w_sda};
                else if (s_st == 3) s_mack <= w_sda;
                s_bit <= s_bit + 1;
            end
        end else if (p_scl && !w_scl) begin
            case (s_st)
                1: begin
                    if (s_bit == 8) begin
                        if (s_sh[7:1] == SLV) begin
                            s_drv <= 1'b1;
                            s_rw  <= s_sh[0];
                        end else begin
                            s_st <= 4;
                        end
                    end else if (s_bit == 9) begin
                        s_bit <= 0;
                        if (s_rw) begin
                            s_st  <= 3;
                            s_drv <= ~s_io[7];
                        end else begin
                            s_st  <= 2;
                            s_drv <= 1'b0;
                        end
                    end
                end
                2: begin
                    if (s_bit == 8) begin
                        s_io  <= s_sh;
                        s_drv <= 1'b1;
                    end else if (s_bit == 9) begin
                        s_drv <= 1'b0;
                        s_st  <= 4;
                    end
                end
                3: begin
                    if (s_bit >= 1 && s_bit <= 7) s_drv <= ~s_io[3'(7 - s_bit)];
                    else if (s_bit == 8) s_drv <= 1'b0;
                    else if (s_bit == 9) s_st <= 4;
                end
                default: s_drv <= 1'b0;
            endcase
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: expected (scl_low, sda_low) per quarter bit of the transaction
    logic [1:0] m_wave[$];
    int         m_idx = 0;
    logic       m_rw = 1'b0;
    logic [7:0] m_wd = 8'd0;
    logic       m_nack_exp = 1'b0;
    logic [7:0] m_rdata = 8'd0;
    logic [7:0] m_rdata_exp = 8'd0;
    logic [7:0] m_io = 8'hFF;
    logic       chk_en = 1'b0;
    int         t = 0, hs_cnt = 0, rsp_cnt = 0, t_hs = 0, t_rsp = 0, last_lat = 0;
    logic       last_nack = 1'b0;
    logic [7:0] last_rdata = 8'd0;

    function automatic void push_bit(input logic pull);
        m_wave.push_back({1'b1, pull});
        m_wave.push_back({1'b0, pull});
        m_wave.push_back({1'b0, pull});
        m_wave.push_back({1'b1, pull});
    endfunction

    function automatic void build(input logic rw, input logic [6:0] adr, input logic [7:0] wd);
        logic [7:0] ab;
        ab = {adr, rw};
        m_wave.delete();
        m_wave.push_back(2'b00); m_wave.push_back(2'b00);
        m_wave.push_back(2'b01); m_wave.push_back(2'b11);
        for (int i = 7; i >= 0; i--) push_bit(~ab[i]);
        push_bit(1'b0);
        if (adr == SLV) begin
            for (int i = 7; i >= 0; i--) push_bit(rw ? 1'b0 : ~wd[i]);
            push_bit(1'b0);
        end
        m_wave.push_back(2'b11); m_wave.push_back(2'b01);
        m_wave.push_back(2'b00); m_wave.push_back(2'b00);
    endfunction

    initial begin
        forever begin : cmp
            logic [13:0] e;
            logic [13:0] a;
            logic        was_idle;
            @(negedge clk);
            t++;
            if (chk_en) begin
                was_idle = (m_idx == 0);
                if (m_idx == 0) begin
                    e = {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, m_rdata};
                end else if (m_idx <= m_wave.size() * CD) begin
                    e = {m_wave[(m_idx - 1) / CD], 1'b1, 1'b0, 1'b0, 1'b0, m_rdata};
                end else begin
                    e = {2'b00, 1'b1, 1'b0, 1'b1, m_nack_exp, m_rdata_exp};
                end
                a = {scl_low, sda_low, busy, cmd_ready, rsp_valid, e[9] ? rsp_nack : 1'b0, rsp_rdata};
                chk($sformatf("outputs t=%0d idx=%0d {scl,sda,busy,rdy,vld,nack,rdata}", t, m_idx),
                    32'(a), 32'(e));
                if (m_idx > m_wave.size() * CD) begin
                    m_rdata = m_rdata_exp;
                    if (!m_rw && !m_nack_exp) m_io = m_wd;
                    rsp_cnt++;
                    t_rsp      = t;
                    last_lat   = m_idx;
                    last_nack  = rsp_nack;
                    last_rdata = rsp_rdata;
                    m_idx      = 0;
                end else if (m_idx > 0) begin
                    m_idx++;
                end
                if (rst) begin
                    m_idx   = 0;
                    m_rdata = 8'd0;
                end else if (was_idle && cmd_valid) begin
                    build(cmd_rw, cmd_adr, cmd_wdata);
                    m_rw        = cmd_rw;
                    m_wd        = cmd_wdata;
                    m_nack_exp  = (cmd_adr != SLV);
                    m_rdata_exp = (cmd_rw && cmd_adr == SLV) ? m_io : m_rdata;
                    m_idx       = 1;
                    hs_cnt++;
                    t_hs = t;
                end
            end
        end
    end

    task automatic wait_hs(input int target);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (hs_cnt >= target) break;
        end
        chk("accept within bound", 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (rsp_cnt >= target) break;
        end
        chk("response within bound", 32'(rsp_cnt >= target), 32'd1);
    endtask

    task automatic do_cmd(input logic rw, input logic [6:0] adr, input logic [7:0] wd);
        int h0;
        int r0;
        h0 = hs_cnt;
        r0 = rsp_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_adr = adr; cmd_wdata = wd;
        wait_hs(h0 + 1);
        #1 cmd_valid = 1'b0;
        wait_rsp(r0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int h0;
        int r0;
        int st0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset busy/valid/scl/sda", 32'({busy, rsp_valid, scl_low, sda_low}), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'h00);

        // read from a freshly reset slave
        do_cmd(1'b1, SLV, 8'h00);
        chk("fresh read rdata", 32'(last_rdata), 32'hFF);
        chk("fresh read nack", 32'(last_nack), 32'd0);

        // write A5
        do_cmd(1'b0, SLV, 8'hA5);
        chk("write latency", 32'(last_lat), 32'd321);
        chk("write nack", 32'(last_nack), 32'd0);
        chk("write IOout", 32'(s_io), 32'hA5);

        // read back
        do_cmd(1'b1, SLV, 8'h00);
        chk("read rdata", 32'(last_rdata), 32'hA5);
        chk("read nack", 32'(last_nack), 32'd0);
        chk("read master NACK bit", 32'(s_mack), 32'd1);
        chk("read latency", 32'(last_lat), 32'd321);

        // address NACK
        st0 = s_stops;
        do_cmd(1'b0, 7'h71, 8'h3C);
        chk("adr nack latency", 32'(last_lat), 32'd177);
        chk("adr nack flag", 32'(last_nack), 32'd1);
        chk("adr nack IOout kept", 32'(s_io), 32'hA5);
        chk("adr nack STOP seen", 32'(s_stops), 32'(st0 + 1));

        // cmd_valid held across two writes
        h0 = hs_cnt;
        r0 = rsp_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_adr = SLV; cmd_wdata = 8'h01;
        wait_hs(h0 + 1);
        #1 cmd_wdata = 8'h02;
        wait_hs(h0 + 2);
        #1 cmd_valid = 1'b0;
        chk("b2b accept gap", 32'(t_hs - t_rsp), 32'd1);
        wait_rsp(r0 + 2);
        chk("b2b accept count", 32'(hs_cnt), 32'(h0 + 2));
        chk("b2b IOout", 32'(s_io), 32'h02);

        // reset at tick 50 of a write
        h0 = hs_cnt;
        r0 = rsp_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_adr = SLV; cmd_wdata = 8'h77;
        wait_hs(h0 + 1);
        #1 cmd_valid = 1'b0;
        repeat (199) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset lines", 32'({scl_low, sda_low}), 32'd0);
        chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post-reset rsp_rdata", 32'(rsp_rdata), 32'h00);
        repeat (400) @(posedge clk);
        chk("no rsp after reset", 32'(rsp_cnt), 32'(r0));
        do_cmd(1'b0, SLV, 8'h5A);
        chk("after-reset write nack", 32'(last_nack), 32'd0);
        chk("after-reset IOout", 32'(s_io), 32'h5A);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
